// File: rtl/lamp_seq_pkg.sv
// Shared definitions for the lamp sequencer: phase encoding, level-to-lamp decode, level-point sanity check.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lamp_seq_pkg;

    // Phase 0 is idle; 1..6 are the ramp phases. Odd phases ramp up, even phases ramp down.
    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_UP1  = 3'd1,
        PH_DN2  = 3'd2,
        PH_UP3  = 3'd3,
        PH_DN4  = 3'd4,
        PH_UP5  = 3'd5,
        PH_DN6  = 3'd6
    } phase_e;

    // One lamp bit for a given level: bar lights every lamp below the level,
    // dot lights only the lamp at position level-1 (nothing at level 0).
    function automatic logic lamp_bit(input int unsigned lvl, input int unsigned idx, input logic dot);
        return dot ? (lvl == idx + 1) : (idx < lvl);
    endfunction

    // Level points must be strictly ordered inside the lamp range.
    function automatic bit lvl_points_ok(input int n_lamp, input int lvl_b, input int lvl_c);
        return (lvl_b > 0) && (lvl_b < lvl_c) && (lvl_c < n_lamp);
    endfunction

endpackage

// File: rtl/lamp_step_tick.sv
// Step-rate prescaler: one tick every step_div+1 enabled clocks.
// Latency: tick is combinational from the count register and live step_div.
// Backpressure: none; a shrinking step_div just lets the count run to its max and wrap.
module lamp_step_tick #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] step_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick = en && (cnt_q == step_div);

    // Next count: clear on start, wrap on tick, otherwise count up (natural wrap covers count > step_div).
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lamp_seq_gen.sv
// N-lamp six-phase up/down sequencer with prescaler, bar/dot display, repeat count and status.
// Latency: level moves on the clock edge that sees a tick; lamp follows level in the same cycle.
// Backpressure: none; flick is only honoured in idle and at the two retrigger points.
module lamp_seq_gen
    import lamp_seq_pkg::*;
#(
    parameter int N_LAMP = 16,
    parameter int LVL_B  = 5,
    parameter int LVL_C  = 10,
    parameter int DIV_W  = 8,
    parameter int LOOP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flick,
    input  logic [DIV_W-1:0]  step_div,
    input  logic              mode,
    input  logic [LOOP_W-1:0] loops,
    output logic [N_LAMP-1:0] lamp,
    output logic              busy,
    output logic              done,
    output logic [2:0]        phase
);

    localparam int LVL_W = $clog2(N_LAMP + 1);
    localparam logic [LVL_W-1:0] LV_N = LVL_W'(N_LAMP);
    localparam logic [LVL_W-1:0] LV_B = LVL_W'(LVL_B);
    localparam logic [LVL_W-1:0] LV_C = LVL_W'(LVL_C);
    localparam logic [LVL_W-1:0] ONE  = LVL_W'(1);

    if (!lvl_points_ok(N_LAMP, LVL_B, LVL_C)) begin : g_bad_lvl
        $error("lamp_seq_gen: level points must satisfy 0 < LVL_B < LVL_C < N_LAMP");
    end

    phase_e            phase_q;
    logic [LVL_W-1:0]  level_q;
    logic [LOOP_W-1:0] loop_q;
    logic              mode_q;
    logic              done_q;

    logic              tick;
    logic              start;
    logic              up_ramp;
    logic [LVL_W-1:0]  tgt;

    assign start   = (phase_q == PH_IDLE) && flick;
    assign up_ramp = (phase_q == PH_UP1) || (phase_q == PH_UP3) || (phase_q == PH_UP5);

    lamp_step_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (phase_q != PH_IDLE),
        .clr      (start),
        .step_div (step_div),
        .tick     (tick)
    );

    // Ramp target of the current phase.
    always_comb begin
        tgt = '0;
        case (phase_q)
            PH_UP1:  tgt = LV_N;
            PH_DN2:  tgt = LV_B;
            PH_UP3:  tgt = LV_C;
            PH_UP5:  tgt = LV_B;
            default: tgt = '0;
        endcase
    end

    // Sequencer: start from idle, then on each tick retrigger, step, change phase, repeat or finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_IDLE;
            level_q <= '0;
            loop_q  <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (phase_q == PH_IDLE) begin
                level_q <= '0;
                if (flick) begin
                    mode_q  <= mode;
                    loop_q  <= loops;
                    phase_q <= PH_UP1;
                    level_q <= ONE;
                end
            end else if (tick) begin
                if (phase_q == PH_DN2 && level_q == LV_B && flick) begin
                    phase_q <= PH_UP1;
                    level_q <= LV_B + ONE;
                end else if (phase_q == PH_DN4 && (level_q == LV_B || level_q == '0) && flick) begin
                    phase_q <= PH_UP3;
                    level_q <= level_q + ONE;
                end else if (level_q != tgt) begin
                    level_q <= up_ramp ? level_q + ONE : level_q - ONE;
                end else if (phase_q != PH_DN6) begin
                    // Endpoint reached: next phase has the opposite direction, so step away at once.
                    phase_q <= phase_e'(phase_q + 3'd1);
                    level_q <= up_ramp ? level_q - ONE : level_q + ONE;
                end else if (loop_q != '0) begin
                    loop_q  <= loop_q - LOOP_W'(1);
                    phase_q <= PH_UP1;
                    level_q <= ONE;
                end else begin
                    phase_q <= PH_IDLE;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    // Lamp decode straight from the level and latched mode registers.
    always_comb begin
        lamp = '0;
        for (int i = 0; i < N_LAMP; i++) begin
            lamp[i] = lamp_bit(32'(level_q), 32'(i), mode_q);
        end
    end

    assign busy  = (phase_q != PH_IDLE);
    assign done  = done_q;
    assign phase = phase_q;

endmodule

// File: tb/tb_lamp_seq_gen.sv
// Self-checking bench for lamp_seq_gen: scenario table, hand-written corner sequences, random runs against a level-list model.
// Latency: n/a.
// Backpressure: n/a.
module tb_lamp_seq_gen;

    localparam int N  = 16;
    localparam int LB = 5;
    localparam int LC = 10;
    localparam int DW = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flick = 1'b0;
    logic          mode = 1'b0;
    logic [DW-1:0] step_div = '0;
    logic [LW-1:0] loops = '0;
    logic [N-1:0]  lamp;
    logic          busy;
    logic          done;
    logic [2:0]    phase;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    lamp_seq_gen #(
        .N_LAMP (N),
        .LVL_B  (LB),
        .LVL_C  (LC),
        .DIV_W  (DW),
        .LOOP_W (LW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flick    (flick),
        .step_div (step_div),
        .mode     (mode),
        .loops    (loops),
        .lamp     (lamp),
        .busy     (busy),
        .done     (done),
        .phase    (phase)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Expected lamp pattern for a level, straight from the bar/dot definition.
    function automatic logic [N-1:0] lamp_of(input int lvl, input bit dot);
        logic [N-1:0] r;
        r = '0;
        if (dot) begin
            if (lvl > 0) r[lvl-1] = 1'b1;
        end else begin
            for (int i = 0; i < lvl; i++) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Model: list of (level, phase) per step, built by walking between the phase targets.
    typedef struct { int lvl; int ph; } step_t;
    step_t exp_q[$];

    function automatic void build(input int n_loops);
        int tg[6];
        tg = '{N, LB, LC, 0, LB, 0};
        exp_q.delete();
        for (int p = 0; p <= n_loops; p++) begin
            int lvl = 1;
            exp_q.push_back('{1, 1});
            for (int ph = 1; ph <= 6; ph++) begin
                while (lvl != tg[ph-1]) begin
                    lvl += (lvl < tg[ph-1]) ? 1 : -1;
                    exp_q.push_back('{lvl, ph});
                end
            end
        end
    endfunction

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after an edge while idle; returns #1 after the start edge (first cycle of phase 1).
    task automatic start(input int d, input bit m, input int l);
        step_div = DW'(d);
        mode     = m;
        loops    = LW'(l);
        flick    = 1'b1;
        adv(1);
        flick    = 1'b0;
    endtask

    // Wait for busy to drop, bounded; n = cycles waited.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 5000) begin
            adv(1);
            n++;
        end
        if (n >= 5000) begin
            n_chk++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", n);
        end
    endtask

    typedef struct {
        int           div;
        bit           m;
        int           lp;
        int           exp_len;
        logic [N-1:0] exp_peak;
    } vec_t;

    vec_t tbl[5];

    task automatic run_vec(input vec_t v);
        int cyc;
        int dones;
        start(v.div, v.m, v.lp);
        chk("vec_first_lamp", 32'(lamp), 32'h0001);
        cyc   = 0;
        dones = 0;
        while (busy && cyc < 5000) begin
            if (cyc == 15 * (v.div + 1)) chk("vec_peak", 32'(lamp), 32'(v.exp_peak));
            if (done) dones++;
            adv(1);
            cyc++;
        end
        chk("vec_busy_len", 32'(cyc), 32'(v.exp_len));
        chk("vec_no_early_done", 32'(dones), 32'd0);
        chk("vec_done_at_fall", 32'(done), 32'd1);
        adv(1);
        chk("vec_done_one_clk", 32'(done), 32'd0);
    endtask

    task automatic run_model(input int d, input bit m, input int l);
        build(l);
        start(d, m, l);
        foreach (exp_q[k]) begin
            chk("rnd_busy", 32'(busy), 32'd1);
            for (int r = 0; r <= d; r++) begin
                chk("rnd_lamp", 32'(lamp), 32'(lamp_of(exp_q[k].lvl, m)));
                chk("rnd_phase", 32'(phase), 32'(exp_q[k].ph));
                chk("rnd_done_low", 32'(done), 32'd0);
                adv(1);
            end
        end
        chk("rnd_busy_end", 32'(busy), 32'd0);
        chk("rnd_done", 32'(done), 32'd1);
        adv(1);
        chk("rnd_done_off", 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        tbl[0] = '{0, 1'b0, 0, 52,  16'hFFFF};
        tbl[1] = '{3, 1'b0, 0, 208, 16'hFFFF};
        tbl[2] = '{0, 1'b1, 0, 52,  16'h8000};
        tbl[3] = '{0, 1'b0, 2, 156, 16'hFFFF};
        tbl[4] = '{1, 1'b1, 1, 208, 16'h8000};

        // Reset state.
        #12;
        chk("rst_lamp", 32'(lamp), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        adv(3);
        chk("idle_lamp", 32'(lamp), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Scenario table.
        for (int i = 0; i < 5; i++) begin
            run_vec(tbl[i]);
            adv(2);
        end

        // Retrigger in phase 2 at the low turnaround point, then release into phase 3.
        start(0, 1'b0, 0);
        adv(16);
        flick = 1'b1;
        adv(11);
        chk("retrig_lamp", 32'(lamp), 32'h003F);
        chk("retrig_phase", 32'(phase), 32'd1);
        adv(10);
        chk("retrig_top", 32'(lamp), 32'hFFFF);
        adv(3);
        flick = 1'b0;
        adv(8);
        chk("retrig_low", 32'(lamp), 32'h001F);
        chk("retrig_low_ph", 32'(phase), 32'd2);
        adv(1);
        chk("retrig_ph3_lamp", 32'(lamp), 32'h003F);
        chk("retrig_ph3", 32'(phase), 32'd3);
        wait_idle(n);
        adv(2);

        // Mode toggled mid-pass keeps the latched dot display.
        start(0, 1'b1, 0);
        adv(5);
        mode = 1'b0;
        adv(10);
        chk("mode_latched", 32'(lamp), 32'h8000);
        wait_idle(n);
        adv(2);

        // Prescaler count left above a shrunk step_div runs to max and wraps.
        start(7, 1'b0, 0);
        adv(5);
        step_div = DW'(1);
        adv(100);
        chk("presc_hold", 32'(lamp), 32'h0001);
        wait_idle(n);
        chk("presc_len", 32'(105 + n), 32'd360);
        chk("presc_done", 32'(done), 32'd1);
        adv(2);

        // Asynchronous reset in phase 3 at 0x00FF.
        start(0, 1'b0, 0);
        adv(29);
        chk("pre_rst_lamp", 32'(lamp), 32'h00FF);
        chk("pre_rst_phase", 32'(phase), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_lamp", 32'(lamp), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_phase", 32'(phase), 32'd0);
        adv(2);
        chk("arst_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            adv(1);
            chk("post_rst_lamp", 32'(lamp), 32'd0);
            chk("post_rst_done", 32'(done), 32'd0);
        end
        start(0, 1'b0, 0);
        chk("restart_lamp", 32'(lamp), 32'h0001);
        wait_idle(n);
        adv(2);

        // Random runs against the model.
        for (int i = 0; i < 6; i++) begin
            run_model(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
            adv(int'($urandom_range(1, 4)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lamp_seq_gen.md
Name: lamp_seq_gen

Overview:
Parametrised successor of the 16-lamp flicker sequencer. It drives an N-lamp bar through a six-phase up/down pattern with three programmable level points. Added over the previous generation: a step-rate prescaler, bar or dot display mode, a repeat count, and busy, done and phase status outputs. It sits between the board flick input (already synchronised upstream) and the LED pins.

Parameters:
N_LAMP, 16, number of lamps; level range 0..N_LAMP
LVL_B, 5, low turnaround level; 0 < LVL_B < LVL_C
LVL_C, 10, mid turnaround level; LVL_C < N_LAMP
DIV_W, 8, width of step_div
LOOP_W, 4, width of loops
(localparam LVL_W = $clog2(N_LAMP+1))

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
flick  in  1  start / retrigger request, level-sensitive
step_div  in  DIV_W  one step every step_div+1 clocks; sampled live
mode  in  1  0 = bar (thermometer), 1 = dot (one-hot); latched at start
loops  in  LOOP_W  extra passes; latched at start; pattern runs loops+1 times
lamp  out  N_LAMP  lamp drive
busy  out  1  high while state != IDLE
done  out  1  one-clock pulse when the final pass ends
phase  out  3  0 = IDLE, 1..6 = current phase

Behaviour:
- Reset (async): state=IDLE, level=0, prescaler=0, loop counter=0, mode_q=0, done=0. Outputs: lamp=0, busy=0, phase=0.
- Lamp decode (combinational from registers):
  - Bar mode: lamp = (1<<level)-1.
  - Dot mode: lamp = 0 when level=0, else 1<<(level-1).
- Prescaler:
  - Runs only when state != IDLE. Cleared on the start edge.
  - tick=1 when prescaler==step_div, then prescaler wraps to 0.
  - If step_div changes so that prescaler > step_div, the prescaler counts up to its max and wraps. No lockup.
- IDLE: on a clock edge with flick=1:
  - latch mode and loops;
  - move to phase 1 with level=1, no tick wait.
  - Otherwise stay in IDLE with level=0.
- Phases and targets:
  - 1 = UP to N_LAMP
  - 2 = DOWN to LVL_B
  - 3 = UP to LVL_C
  - 4 = DOWN to 0
  - 5 = UP to LVL_B
  - 6 = DOWN to 0
- On each tick, in priority order:
  - (a) Retrigger, phase 2, level==LVL_B, flick=1: go to phase 1, level=LVL_B+1.
  - (b) Retrigger, phase 4, level==LVL_B or level==0, flick=1: go to phase 3, level+1.
  - (c) level != target: level steps by 1 toward target.
  - (d) level == target in phases 1..5: advance to the next phase; level steps by 1 toward the new target. Endpoints therefore dwell for exactly one step.
  - (e) Phase 6 at level 0 with loop counter > 0: decrement the counter; go to phase 1, level=1.
  - (f) Phase 6 at level 0 with loop counter == 0: go to IDLE; done=1 for one clock.
- flick is ignored at every other point, including mid-ramp and during the pass restart in (e).
- One pass is 52 steps for the default parameters: 16+11+5+10+5+5.
- No cycle is added between a tick and the level update. lamp follows level in the same cycle.
- rst_n asserted mid-pattern aborts immediately with no done pulse. After release the block waits in IDLE for flick.

Decomposition:
- Package lamp_seq_pkg holds the phase encoding constants (PH_IDLE..PH_DN6), a decode function for level-to-lamp, and the constraints on level points.
- One natural sub-module, lamp_step_tick: the prescaler (clk, rst_n, en, clr, step_div -> tick).
- FSM, level counter and loop counter stay in lamp_seq_gen.

Test Plan:
- Defaults, step_div=0, mode=0, loops=0, 1-clk flick pulse -> lamp 0x0001,0x0003..0xFFFF, 0x7FFF..0x001F, 0x003F..0x03FF, 0x01FF..0x0000, 0x0001..0x001F, 0x000F..0x0000. busy high exactly 52 clks; done 1 clk as busy falls.
- step_div=3, same stimulus -> each lamp value held 4 clks; busy high 208 clks.
- flick held high from entry of phase 2 -> at lamp=0x001F the pattern returns to 0x003F, 0x007F..0xFFFF. It repeats phases 1-2 while flick stays high; after flick drops, the pattern continues 0x003F..0x03FF (phase 3).
- mode=1 -> lamp 0x0001,0x0002..0x8000, 0x4000..0x0010. Toggling mode mid-pass has no effect until the next start.
- loops=2 -> three back-to-back passes with lamp=0x0001 directly after each 0x0000 end. busy continuous for 156 clks; single done pulse.
- rst_n low during phase 3 at lamp=0x00FF -> lamp=0, busy=0, phase=0 asynchronously; no done pulse. After release, flick=0 keeps lamp=0; a new flick restarts at 0x0001.
